// File: rtl/brisc_pkg.sv
// brisc_pkg: shared memory-port types and pipeline depths.
//   mem_req_t  : valid, rw (1 = write), addr, one line of data
//   mem_resp_t : ready, addr, one line of data
package brisc_pkg;
    localparam int MEM_REQ_DELAY  = 5;
    localparam int MEM_RESP_DELAY = 5;
    localparam int ADDR_W         = 32;
    localparam int LINE_W         = 128;

    typedef struct packed {
        logic              valid;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic              ready;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } mem_resp_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges I-cache and D-cache requests onto one memory port, one transaction at a time.
//   clk, rst_n          : clock, asynchronous active-low reset
//   icache_req_i/resp_o : I-cache request in, completion out
//   dcache_req_i/resp_o : D-cache request in, completion out
//   mem_req_o           : registered request to memory (valid pulses one cycle per transaction)
//   mem_resp_i          : read fill from memory
//   err_o               : sticky flag for unexpected or mismatched memory responses
module mem_arbiter #(
    parameter int MEM_REQ_DELAY  = brisc_pkg::MEM_REQ_DELAY,
    parameter int MEM_RESP_DELAY = brisc_pkg::MEM_RESP_DELAY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  brisc_pkg::mem_req_t  icache_req_i,
    output brisc_pkg::mem_resp_t icache_resp_o,
    input  brisc_pkg::mem_req_t  dcache_req_i,
    output brisc_pkg::mem_resp_t dcache_resp_o,
    output brisc_pkg::mem_req_t  mem_req_o,
    input  brisc_pkg::mem_resp_t mem_resp_i,
    output logic                 err_o
);
    localparam int CW = $clog2(MEM_REQ_DELAY + MEM_RESP_DELAY + 1);

    typedef enum logic [1:0] {DRAIN, IDLE, WAIT_RD, WAIT_WR} state_t;

    state_t               r_state, w_state_nx;
    logic [CW-1:0]        r_cnt, w_cnt_nx;
    logic                 r_owner, r_last_grant, r_err;
    brisc_pkg::mem_req_t  r_req, w_sel;
    brisc_pkg::mem_resp_t w_resp;
    logic                 w_pick, w_grant, w_rd_done, w_wr_done, w_bad_resp;

    // Round-robin only matters on a conflict; otherwise take whichever client is valid.
    assign w_pick    = (icache_req_i.valid && dcache_req_i.valid) ? ~r_last_grant : dcache_req_i.valid;
    assign w_sel     = w_pick ? dcache_req_i : icache_req_i;
    assign w_grant   = (r_state == IDLE) && (icache_req_i.valid || dcache_req_i.valid);
    assign w_rd_done = (r_state == WAIT_RD) && mem_resp_i.ready;
    assign w_wr_done = (r_state == WAIT_WR) && (r_cnt == '0);
    // DRAIN absorbs stale fills from before reset, so it never flags.
    assign w_bad_resp = mem_resp_i.ready && ((r_state == IDLE) || (r_state == WAIT_WR) ||
                        ((r_state == WAIT_RD) && (mem_resp_i.addr != r_req.addr)));

    assign w_resp = w_rd_done ? mem_resp_i :
                    w_wr_done ? {1'b1, r_req.addr, {brisc_pkg::LINE_W{1'b0}}} : '0;

    assign icache_resp_o = r_owner ? '0 : w_resp;
    assign dcache_resp_o = r_owner ? w_resp : '0;
    assign mem_req_o     = r_req;
    assign err_o         = r_err;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            DRAIN: begin
                w_cnt_nx   = (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
                w_state_nx = (r_cnt <= CW'(1)) ? IDLE : DRAIN;
            end
            IDLE: begin
                // Loaded at grant: holds MEM_REQ_DELAY in the issue cycle, hits zero in the
                // cycle whose closing edge commits the write in memory.
                w_cnt_nx   = CW'(MEM_REQ_DELAY);
                w_state_nx = !w_grant ? IDLE : (w_sel.rw ? WAIT_WR : WAIT_RD);
            end
            WAIT_RD: w_state_nx = w_rd_done ? IDLE : WAIT_RD;
            WAIT_WR: begin
                w_cnt_nx   = r_cnt - CW'(1);
                w_state_nx = w_wr_done ? IDLE : WAIT_WR;
            end
            default: w_state_nx = DRAIN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= DRAIN;
            r_cnt        <= CW'(MEM_REQ_DELAY + MEM_RESP_DELAY);
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
            r_err        <= 1'b0;
            r_req        <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_err   <= r_err | w_bad_resp;
            if (w_grant) begin
                r_req        <= w_sel;
                r_owner      <= w_pick;
                r_last_grant <= w_pick;
            end else begin
                r_req.valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a pipelined memory model and a response stub.
module tb_mem_arbiter;
    import brisc_pkg::*;

    localparam int REQ  = 5;
    localparam int RESP = 5;

    logic      clk   = 1'b0;
    logic      rst_n = 1'b0;
    logic      stub  = 1'b0;
    logic      err;
    mem_req_t  icache_req, dcache_req, mem_req;
    mem_resp_t icache_resp, dcache_resp, mem_resp, stub_resp;
    int        checks   = 0;
    int        failures = 0;

    // Memory model: unwritten lines read back as the line address replicated in every word.
    logic [127:0] mem [256];
    bit           written [256] = '{default: 1'b0};
    mem_req_t     req_pipe  [REQ]  = '{default: '0};
    mem_resp_t    resp_pipe [RESP] = '{default: '0};

    always #5 clk = ~clk;

    assign mem_resp = stub ? stub_resp : resp_pipe[RESP-1];

    always @(posedge clk) begin
        req_pipe[0] <= mem_req;
        for (int k = 1; k < REQ; k++) req_pipe[k] <= req_pipe[k-1];
        if (req_pipe[REQ-1].valid && req_pipe[REQ-1].rw) begin
            mem[req_pipe[REQ-1].addr[11:4]]     <= req_pipe[REQ-1].data;
            written[req_pipe[REQ-1].addr[11:4]] <= 1'b1;
        end
        resp_pipe[0] <= '{ready: req_pipe[REQ-1].valid && !req_pipe[REQ-1].rw,
                          addr:  req_pipe[REQ-1].addr,
                          data:  written[req_pipe[REQ-1].addr[11:4]] ? mem[req_pipe[REQ-1].addr[11:4]]
                                                                      : {4{req_pipe[REQ-1].addr}}};
        for (int k = 1; k < RESP; k++) resp_pipe[k] <= resp_pipe[k-1];
    end

    mem_arbiter #(.MEM_REQ_DELAY(REQ), .MEM_RESP_DELAY(RESP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .icache_req_i (icache_req),
        .icache_resp_o(icache_resp),
        .dcache_req_i (dcache_req),
        .dcache_resp_o(dcache_resp),
        .mem_req_o    (mem_req),
        .mem_resp_i   (mem_resp),
        .err_o        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycles until mem_req.valid (-1 on timeout); spur counts client completions seen meanwhile.
    task automatic wait_issue(input int bound, output int n, output int spur);
        n = 0;
        spur = 0;
        do begin
            tick();
            n++;
            spur += int'(icache_resp.ready | dcache_resp.ready);
        end while (!mem_req.valid && n < bound);
        if (!mem_req.valid) n = -1;
    endtask

    // Cycles until the client's resp.ready (-1 on timeout); vcnt counts extra mem_req.valid cycles.
    task automatic wait_done(input bit d, input int bound, output int n, output int vcnt);
        n = 0;
        vcnt = 0;
        do begin
            tick();
            n++;
            vcnt += int'(mem_req.valid);
        end while (!(d ? dcache_resp.ready : icache_resp.ready) && n < bound);
        if (!(d ? dcache_resp.ready : icache_resp.ready)) n = -1;
    endtask

    initial begin
        int n, s;
        icache_req = '0;
        dcache_req = '0;
        stub_resp  = '0;
        tick();
        tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_iresp", icache_resp, 0);
        chk("rst_dresp", dcache_resp, 0);
        chk("rst_err", err, 0);

        // Drain after reset, then a single read of a preloaded line.
        icache_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h100, data: '0};
        rst_n = 1'b1;
        wait_issue(20, n, s);
        chk("drain_issue_lat", n, 11);
        chk("drain_spurious", s, 0);
        chk("rd_issue_addr", mem_req.addr, 32'h100);
        chk("rd_issue_rw", mem_req.rw, 0);
        wait_done(0, 20, n, s);
        chk("rd_lat", n, 10);
        chk("rd_single_pulse", s, 0);
        chk("rd_resp", icache_resp, {1'b1, 32'h100, {4{32'h100}}});
        chk("rd_dresp_zero", dcache_resp, 0);
        chk("rd_err", err, 0);
        icache_req = '0;

        // Write then read back.
        dcache_req = '{valid: 1'b1, rw: 1'b1, addr: 32'h200, data: {4{32'hDEADBEEF}}};
        wait_issue(20, n, s);
        chk("wr_issue_lat", n, 2);
        chk("wr_issue_rw", mem_req.rw, 1);
        chk("wr_issue_addr", mem_req.addr, 32'h200);
        wait_done(1, 20, n, s);
        chk("wr_lat", n, 5);
        chk("wr_resp", dcache_resp, {1'b1, 32'h200, 128'h0});
        chk("wr_iresp_zero", icache_resp, 0);
        dcache_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h200, data: '0};
        wait_issue(20, n, s);
        chk("wr_rd_gap", n, 2);
        wait_done(1, 20, n, s);
        chk("wr_rd_lat", n, 10);
        chk("wr_rd_data", dcache_resp, {1'b1, 32'h200, {4{32'hDEADBEEF}}});
        dcache_req = '0;

        // Conflict right after reset: dcache wins first.
        rst_n = 1'b0;
        tick();
        icache_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h40, data: '0};
        dcache_req = '{valid: 1'b1, rw: 1'b1, addr: 32'h80, data: {4{32'h12345678}}};
        rst_n = 1'b1;
        wait_issue(20, n, s);
        chk("conf_issue_lat", n, 11);
        chk("conf_first", {mem_req.rw, mem_req.addr}, {1'b1, 32'h80});
        wait_done(1, 20, n, s);
        chk("conf_wr_lat", n, 5);
        dcache_req = '0;
        wait_issue(20, n, s);
        chk("conf_second_gap", n, 2);
        chk("conf_second", {mem_req.rw, mem_req.addr}, {1'b0, 32'h40});
        wait_done(0, 20, n, s);
        chk("conf_rd_lat", n, 10);
        chk("conf_rd_resp", icache_resp, {1'b1, 32'h40, {4{32'h40}}});
        icache_req = '0;

        // Reset three cycles into a read.
        icache_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h80, data: '0};
        wait_issue(20, n, s);
        chk("mid_issue_lat", n, 2);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_iresp", icache_resp, 0);
        chk("mid_rst_err", err, 0);
        tick();
        rst_n = 1'b1;
        wait_issue(20, n, s);
        chk("mid_redrain_lat", n, 11);
        chk("mid_stale_dropped", s, 0);
        chk("mid_stale_err", err, 0);
        wait_done(0, 20, n, s);
        chk("mid_rd_lat", n, 10);
        chk("mid_rd_resp", icache_resp, {1'b1, 32'h80, {4{32'h12345678}}});
        icache_req = '0;

        // Protocol errors with the memory stubbed.
        stub = 1'b1;
        tick();
        stub_resp = '{ready: 1'b1, addr: 32'h300, data: 128'h0};
        #1;
        chk("idle_resp_not_fwd", {icache_resp, dcache_resp}, 0);
        tick();
        stub_resp = '0;
        chk("err_idle", err, 1);
        tick();
        tick();
        tick();
        chk("err_sticky", err, 1);
        rst_n = 1'b0;
        #1;
        chk("err_clear", err, 0);
        tick();
        rst_n = 1'b1;
        icache_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h500, data: '0};
        wait_issue(20, n, s);
        chk("mm_issue_lat", n, 11);
        tick();
        tick();
        stub_resp = '{ready: 1'b1, addr: 32'h504, data: 128'hCAFEF00D_00000001_00000002_00000003};
        #1;
        chk("mm_fwd", icache_resp, {1'b1, 32'h504, 128'hCAFEF00D_00000001_00000002_00000003});
        chk("mm_err_pre", err, 0);
        tick();
        stub_resp  = '0;
        icache_req = '0;
        chk("mm_err", err, 1);
        chk("mm_resp_after", icache_resp, 0);
        dcache_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h600, data: '0};
        wait_issue(20, n, s);
        chk("mm_completed", n, 1);
        chk("mm_err_held", err, 1);
        dcache_req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
